// File: rtl/buf_ram_arbiter.sv
// ============================================================================
// Module   : buf_ram_arbiter
// Purpose  : Round-robin sharing of the single-port 8-bit packet buffer RAM
//            between RX byte writes, TX byte reads and 32-bit controller words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module buf_ram_arbiter #(
  parameter int NUMBER = 256,
  parameter int AW     = $clog2(NUMBER)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_wr_byte,
  input  logic [AW-1:0] wr_addr_byte,
  input  logic [7:0]    wr_byte,
  output logic          done_wr_byte,
  input  logic          start_rd_byte,
  input  logic [AW-1:0] rd_addr_byte,
  output logic [7:0]    rd_byte,
  output logic          done_rd_byte,
  input  logic          start_rd_ram,
  input  logic [AW-1:0] start_rd_addr,
  output logic [31:0]   rd_word,
  output logic          done_rd_ram,
  input  logic          start_wr_ram,
  input  logic [AW-1:0] start_wr_addr,
  input  logic [31:0]   wr_word,
  output logic          done_wr_ram,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_d,
  output logic          ram_we,
  input  logic [7:0]    ram_q,
  output logic          busy,
  output logic          overrun
);

  localparam logic [AW:0] c_number = (AW+1)'(NUMBER);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BYTE_WR = 3'd1,
    S_BYTE_RD = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WORD_RD = 3'd4,
    S_WORD_WR = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_pend;
  logic [1:0]    r_last_grant;
  logic [1:0]    r_grant;
  logic [1:0]    r_k;
  logic [AW-1:0] r_wr_addr_byte, r_rd_addr_byte, r_rd_addr, r_wr_addr;
  logic [7:0]    r_wr_byte;
  logic [31:0]   r_wr_word;
  logic [23:0]   r_word_buf;

  logic          w_found;
  logic [1:0]    w_pick;
  logic [3:0]    w_start, w_accept, w_in_service, w_grant_clr, w_pend_nxt;
  logic [AW-1:0] w_base, w_word_addr;
  logic [AW:0]   w_sum;

  // Round-robin pick: first pending requester after the last one granted
  always_comb begin
    logic [1:0] cand;
    w_found = 1'b0;
    w_pick  = r_last_grant;
    cand    = r_last_grant;
    for (int off = 1; off <= 4; off++) begin
      cand = r_last_grant + off[1:0];
      if (!w_found && r_pend[cand]) begin
        w_found = 1'b1;
        w_pick  = cand;
      end
    end
  end

  always_comb begin
    w_start      = {start_wr_ram, start_rd_ram, start_rd_byte, start_wr_byte};
    w_in_service = (r_state != S_IDLE) ? (4'b0001 << r_grant) : 4'b0000;
    w_accept     = w_start & ~r_pend & ~w_in_service;
    w_grant_clr  = (r_state == S_IDLE && w_found) ? (4'b0001 << w_pick) : 4'b0000;
    w_pend_nxt   = (r_pend & ~w_grant_clr) | w_accept;
  end

  // Word byte address, wrapping at the buffer depth
  always_comb begin
    w_base      = (r_grant == 2'd2) ? r_rd_addr : r_wr_addr;
    w_sum       = {1'b0, w_base} + {{(AW-1){1'b0}}, r_k};
    w_word_addr = (w_sum >= c_number) ? AW'(w_sum - c_number) : w_sum[AW-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          case (w_pick)
            2'd0:    w_state_nxt = S_BYTE_WR;
            2'd1:    w_state_nxt = S_BYTE_RD;
            2'd2:    w_state_nxt = S_WORD_RD;
            default: w_state_nxt = S_WORD_WR;
          endcase
        end
      end
      S_BYTE_WR: w_state_nxt = S_DONE;
      S_BYTE_RD: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: w_state_nxt = S_DONE;
      S_WORD_RD: if (r_k == 2'd3) w_state_nxt = S_RD_WAIT;
      S_WORD_WR: if (r_k == 2'd3) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend         <= 4'b0000;
      r_last_grant   <= 2'd3;
      r_grant        <= 2'd0;
      r_k            <= 2'd0;
      r_wr_addr_byte <= '0;
      r_rd_addr_byte <= '0;
      r_rd_addr      <= '0;
      r_wr_addr      <= '0;
      r_wr_byte      <= 8'h00;
      r_wr_word      <= 32'h0;
      r_word_buf     <= 24'h0;
      done_wr_byte   <= 1'b0;
      done_rd_byte   <= 1'b0;
      done_rd_ram    <= 1'b0;
      done_wr_ram    <= 1'b0;
      ram_addr       <= '0;
      ram_d          <= 8'h00;
      ram_we         <= 1'b0;
      rd_byte        <= 8'h00;
      rd_word        <= 32'h0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      r_pend  <= w_pend_nxt;
      busy    <= (|w_pend_nxt) | (w_state_nxt != S_IDLE);
      overrun <= overrun | (|(w_start & ~w_accept));

      if (w_accept[0]) begin
        r_wr_addr_byte <= wr_addr_byte;
        r_wr_byte      <= wr_byte;
      end
      if (w_accept[1]) r_rd_addr_byte <= rd_addr_byte;
      if (w_accept[2]) r_rd_addr <= start_rd_addr;
      if (w_accept[3]) begin
        r_wr_addr <= start_wr_addr;
        r_wr_word <= wr_word;
      end

      done_wr_byte <= 1'b0;
      done_rd_byte <= 1'b0;
      done_rd_ram  <= 1'b0;
      done_wr_ram  <= 1'b0;
      ram_we       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_k          <= 2'd0;
          end
        end
        S_BYTE_WR: begin
          ram_we   <= 1'b1;
          ram_addr <= r_wr_addr_byte;
          ram_d    <= r_wr_byte;
        end
        S_BYTE_RD: ram_addr <= r_rd_addr_byte;
        S_WORD_WR: begin
          ram_we   <= 1'b1;
          ram_addr <= w_word_addr;
          ram_d    <= r_wr_word[{r_k, 3'b000} +: 8];
          r_k      <= r_k + 2'd1;
        end
        S_WORD_RD: begin
          // RAM data trails its address by two edges, so byte k-2 lands now
          ram_addr <= w_word_addr;
          if (r_k >= 2'd2) r_word_buf[{r_k - 2'd2, 3'b000} +: 8] <= ram_q;
          r_k      <= r_k + 2'd1;
        end
        S_RD_WAIT: if (r_grant == 2'd2) r_word_buf[23:16] <= ram_q;
        S_DONE: begin
          case (r_grant)
            2'd0: done_wr_byte <= 1'b1;
            2'd1: begin
              done_rd_byte <= 1'b1;
              rd_byte      <= ram_q;
            end
            2'd2: begin
              done_rd_ram <= 1'b1;
              rd_word     <= {ram_q, r_word_buf};
            end
            default: done_wr_ram <= 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_buf_ram_arbiter.sv
// ============================================================================
// Module   : tb_buf_ram_arbiter
// Purpose  : Scoreboard bench for buf_ram_arbiter with a behavioural sync RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buf_ram_arbiter;
  localparam int NUMBER = 256;
  localparam int AW     = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_wr_byte = 1'b0, start_rd_byte = 1'b0;
  logic          start_rd_ram = 1'b0, start_wr_ram = 1'b0;
  logic [AW-1:0] wr_addr_byte = '0, rd_addr_byte = '0, start_rd_addr = '0, start_wr_addr = '0;
  logic [7:0]    wr_byte = 8'h00;
  logic [31:0]   wr_word = 32'h0;
  logic          done_wr_byte, done_rd_byte, done_rd_ram, done_wr_ram;
  logic [7:0]    rd_byte, ram_d;
  logic [31:0]   rd_word;
  logic [AW-1:0] ram_addr;
  logic          ram_we, busy, overrun;
  logic [7:0]    ram_q = 8'h00;
  logic [7:0]    mem [NUMBER];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // {kind, cycle, data} for done pulses; {cycle, addr, data} for RAM writes
  logic [71:0] exp_ev[$], obs_ev[$];
  logic [47:0] exp_wr[$], obs_wr[$];

  buf_ram_arbiter #(.NUMBER(NUMBER), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .start_wr_byte(start_wr_byte), .wr_addr_byte(wr_addr_byte), .wr_byte(wr_byte),
    .done_wr_byte(done_wr_byte),
    .start_rd_byte(start_rd_byte), .rd_addr_byte(rd_addr_byte), .rd_byte(rd_byte),
    .done_rd_byte(done_rd_byte),
    .start_rd_ram(start_rd_ram), .start_rd_addr(start_rd_addr), .rd_word(rd_word),
    .done_rd_ram(done_rd_ram),
    .start_wr_ram(start_wr_ram), .start_wr_addr(start_wr_addr), .wr_word(wr_word),
    .done_wr_ram(done_wr_ram),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (done_wr_byte) obs_ev.push_back({8'd0, cyc, 32'd0});
      if (done_rd_byte) obs_ev.push_back({8'd1, cyc, 24'd0, rd_byte});
      if (done_rd_ram)  obs_ev.push_back({8'd2, cyc, rd_word});
      if (done_wr_ram)  obs_ev.push_back({8'd3, cyc, 32'd0});
      if (ram_we)       obs_wr.push_back({cyc, ram_addr, ram_d});
    end
  end

  task automatic do_reset;
    reset = 1'b1;
    {start_wr_byte, start_rd_byte, start_rd_ram, start_wr_ram} = 4'b0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_ev.delete(); obs_ev.delete(); exp_wr.delete(); obs_wr.delete();
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 200) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout busy still %b after 200 cycles, want 0", nm, busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({done_wr_byte, done_rd_byte, done_rd_ram, done_wr_ram, ram_we, ram_addr, ram_d,
         rd_byte, rd_word, busy, overrun} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got we=%b addr=%h d=%h rb=%h rw=%h busy=%b ovr=%b want all 0",
               ram_we, ram_addr, ram_d, rd_byte, rd_word, busy, overrun);
    end
  endtask

  task automatic test_byte_rw;
    int t;
    logic [71:0] e, o;
    logic [47:0] we, wo;
    @(negedge clk);
    wr_addr_byte = 8'h10; wr_byte = 8'hA5; start_wr_byte = 1'b1; t = cyc + 1;
    exp_wr.push_back({t + 2, 8'h10, 8'hA5});
    exp_ev.push_back({8'd0, t + 3, 32'd0});
    @(negedge clk); start_wr_byte = 1'b0;
    wait_idle("byte_wr");
    rd_addr_byte = 8'h10; start_rd_byte = 1'b1; t = cyc + 1;
    exp_ev.push_back({8'd1, t + 4, 32'h0000_00A5});
    @(negedge clk); start_rd_byte = 1'b0;
    wait_idle("byte_rd");
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = (obs_ev.size() > 0) ? obs_ev.pop_front() : '1;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL byte_done got %h want %h", o, e); end
    end
    while (exp_wr.size() > 0) begin
      we = exp_wr.pop_front(); wo = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_cmp++;
      if (wo !== we) begin n_bad++; $display("FAIL byte_ramwr got %h want %h", wo, we); end
    end
    n_cmp++;
    if (obs_ev.size() + obs_wr.size() != 0) begin
      n_bad++; $display("FAIL byte_extra got %0d extra events want 0", obs_ev.size() + obs_wr.size());
    end
  endtask

  task automatic test_word_wrap;
    int t;
    logic [71:0] e, o;
    logic [47:0] we, wo;
    logic [31:0] w;
    w = 32'h1122_3344;
    @(negedge clk);
    start_wr_addr = 8'hFE; wr_word = w; start_wr_ram = 1'b1; t = cyc + 1;
    for (int k = 0; k < 4; k++)
      exp_wr.push_back({t + 2 + k, 8'(8'hFE + k), w[8*k +: 8]});
    exp_ev.push_back({8'd3, t + 6, 32'd0});
    @(negedge clk); start_wr_ram = 1'b0;
    wait_idle("word_wr");
    start_rd_addr = 8'hFE; start_rd_ram = 1'b1; t = cyc + 1;
    exp_ev.push_back({8'd2, t + 7, w});
    @(negedge clk); start_rd_ram = 1'b0;
    wait_idle("word_rd");
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = (obs_ev.size() > 0) ? obs_ev.pop_front() : '1;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL word_done got %h want %h", o, e); end
    end
    while (exp_wr.size() > 0) begin
      we = exp_wr.pop_front(); wo = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_cmp++;
      if (wo !== we) begin n_bad++; $display("FAIL word_ramwr got %h want %h", wo, we); end
    end
  endtask

  task automatic test_round_robin;
    int t;
    logic [71:0] e, o;
    logic [47:0] we, wo;
    logic [31:0] w;
    w = 32'hCAFE_BABE;
    do_reset();
    @(negedge clk);
    wr_addr_byte = 8'h20; wr_byte = 8'h5A; rd_addr_byte = 8'h20;
    start_rd_addr = 8'h20; start_wr_addr = 8'h40; wr_word = w;
    {start_wr_byte, start_rd_byte, start_rd_ram, start_wr_ram} = 4'b1111;
    t = cyc + 1;
    exp_ev.push_back({8'd0, t + 3, 32'd0});
    exp_ev.push_back({8'd1, t + 7, 32'h0000_005A});
    exp_ev.push_back({8'd2, t + 14, 32'h0000_005A});
    exp_ev.push_back({8'd3, t + 20, 32'd0});
    exp_wr.push_back({t + 2, 8'h20, 8'h5A});
    for (int k = 0; k < 4; k++) exp_wr.push_back({t + 16 + k, 8'(8'h40 + k), w[8*k +: 8]});
    @(negedge clk);
    {start_wr_byte, start_rd_byte, start_rd_ram, start_wr_ram} = 4'b0000;
    wait_idle("rr");
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = (obs_ev.size() > 0) ? obs_ev.pop_front() : '1;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL rr_done got %h want %h", o, e); end
    end
    while (exp_wr.size() > 0) begin
      we = exp_wr.pop_front(); wo = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_cmp++;
      if (wo !== we) begin n_bad++; $display("FAIL rr_ramwr got %h want %h", wo, we); end
    end
    n_cmp++;
    if (obs_ev.size() + obs_wr.size() != 0) begin
      n_bad++; $display("FAIL rr_extra got %0d extra events want 0", obs_ev.size() + obs_wr.size());
    end
  endtask

  task automatic test_back_to_back;
    int t, n0, n1;
    logic [71:0] e, o;
    logic [47:0] we, wo;
    @(negedge clk);
    wr_addr_byte = 8'h30; wr_byte = 8'h77; rd_addr_byte = 8'h10;
    start_wr_byte = 1'b1; start_rd_byte = 1'b1; t = cyc + 1; n0 = 1; n1 = 1;
    for (int j = 0; j < 3; j++) begin
      exp_ev.push_back({8'd0, t + 3 + 7*j, 32'd0});
      exp_ev.push_back({8'd1, t + 7 + 7*j, 32'h0000_00A5});
      exp_wr.push_back({t + 2 + 7*j, 8'h30, 8'h77});
    end
    repeat (40) begin
      @(negedge clk);
      start_wr_byte = 1'b0; start_rd_byte = 1'b0;
      if (done_wr_byte && n0 < 3) begin start_wr_byte = 1'b1; n0++; end
      if (done_rd_byte && n1 < 3) begin start_rd_byte = 1'b1; n1++; end
    end
    start_wr_byte = 1'b0; start_rd_byte = 1'b0;
    wait_idle("b2b");
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = (obs_ev.size() > 0) ? obs_ev.pop_front() : '1;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL b2b_done got %h want %h", o, e); end
    end
    while (exp_wr.size() > 0) begin
      we = exp_wr.pop_front(); wo = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_cmp++;
      if (wo !== we) begin n_bad++; $display("FAIL b2b_ramwr got %h want %h", wo, we); end
    end
    n_cmp++;
    if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got %b want 0", overrun); end
  endtask

  task automatic test_overrun;
    int t;
    logic [71:0] e, o;
    logic [47:0] we, wo;
    do_reset();
    @(negedge clk);
    wr_addr_byte = 8'h50; wr_byte = 8'h99; start_wr_byte = 1'b1; t = cyc + 1;
    exp_wr.push_back({t + 2, 8'h50, 8'h99});
    exp_ev.push_back({8'd0, t + 3, 32'd0});
    @(negedge clk);
    wr_addr_byte = 8'h51; wr_byte = 8'h66;
    @(negedge clk); start_wr_byte = 1'b0;
    wait_idle("ovr");
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b want 1", overrun); end
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = (obs_ev.size() > 0) ? obs_ev.pop_front() : '1;
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL ovr_done got %h want %h", o, e); end
    end
    while (exp_wr.size() > 0) begin
      we = exp_wr.pop_front(); wo = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_cmp++;
      if (wo !== we) begin n_bad++; $display("FAIL ovr_ramwr got %h want %h", wo, we); end
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (obs_ev.size() + obs_wr.size() != 0 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_sticky got extra=%0d ovr=%b want extra=0 ovr=1",
               obs_ev.size() + obs_wr.size(), overrun);
    end
  endtask

  task automatic test_reset_mid;
    int t;
    logic [47:0] we, wo;
    do_reset();
    @(negedge clk);
    start_wr_addr = 8'h60; wr_word = 32'hDEAD_BEEF; start_wr_ram = 1'b1; t = cyc + 1;
    exp_wr.push_back({t + 2, 8'h60, 8'hEF});
    exp_wr.push_back({t + 3, 8'h61, 8'hBE});
    @(negedge clk); start_wr_ram = 1'b0;
    while (cyc < t + 3) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({done_wr_byte, done_rd_byte, done_rd_ram, done_wr_ram, ram_we, ram_addr, ram_d,
         rd_byte, rd_word, busy, overrun} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs got we=%b addr=%h d=%h rb=%h rw=%h busy=%b ovr=%b want all 0",
               ram_we, ram_addr, ram_d, rd_byte, rd_word, busy, overrun);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++;
    if (obs_ev.size() != 0) begin
      n_bad++; $display("FAIL rstmid_done got %0d done pulses want 0", obs_ev.size());
    end
    while (exp_wr.size() > 0) begin
      we = exp_wr.pop_front(); wo = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_cmp++;
      if (wo !== we) begin n_bad++; $display("FAIL rstmid_ramwr got %h want %h", wo, we); end
    end
    n_cmp++;
    if (obs_wr.size() != 0) begin
      n_bad++; $display("FAIL rstmid_extra_wr got %0d extra writes want 0", obs_wr.size());
    end
  endtask

  initial begin
    for (int i = 0; i < NUMBER; i++) mem[i] = 8'h00;
    test_reset();
    test_byte_rw();
    test_word_wrap();
    test_round_robin();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/buf_ram_arbiter.md
# buf_ram_arbiter

Shares the single-port 8-bit packet buffer RAM between the UART receiver (byte writes), the UART transmitter (byte reads) and the command state machine (32-bit word reads and writes). Each requester uses a one-cycle start pulse and gets back a one-cycle done pulse. The block queues one request per requester, grants round-robin and sequences word accesses as four byte cycles. It sits between the protocol engines and the buffer RAM, replacing their direct RAM connections.

## Interface
- NUMBER, 256, buffer depth in bytes; AW = clogb2(NUMBER)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_wr_byte  in  1  UART RX byte-write request pulse
- wr_addr_byte  in  AW  RX byte address
- wr_byte  in  8  RX byte data
- done_wr_byte  out  1  RX write complete pulse
- start_rd_byte  in  1  UART TX byte-read request pulse
- rd_addr_byte  in  AW  TX byte address
- rd_byte  out  8  TX read data, valid with done_rd_byte
- done_rd_byte  out  1  TX read complete pulse
- start_rd_ram  in  1  controller word-read request pulse
- start_rd_addr  in  AW  word-read base byte address
- rd_word  out  32  word-read data, valid with done_rd_ram
- done_rd_ram  out  1  word read complete pulse
- start_wr_ram  in  1  controller word-write request pulse
- start_wr_addr  in  AW  word-write base byte address
- wr_word  in  32  word-write data
- done_wr_ram  out  1  word write complete pulse
- ram_addr  out  AW  RAM address
- ram_d  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_q  in  8  RAM read data, valid one cycle after ram_addr
- busy  out  1  high while any request is pending or in service
- overrun  out  1  sticky; set when a start arrives while that requester is already pending or in service

## Operation
- Requesters: index 0 RX write, 1 TX read, 2 ctrl word read, 3 ctrl word write.
- On a start pulse, set pend[i] and latch that requester's address and data. A start arriving while pend[i] is set or i is in service is dropped and sets overrun.
- States: IDLE, BYTE_WR, BYTE_RD, RD_WAIT, WORD_RD, WORD_WR, DONE.
- In IDLE with any pend set:
  - Grant the first set pend after last_grant in the order 0,1,2,3, wrapping.
  - Clear the granted pend[i], update last_grant, go to the access state, set byte counter k=0.
- BYTE_WR: one cycle with ram_we=1 and ram_addr/ram_d from the latch, then DONE.
- BYTE_RD: drive ram_addr for one cycle, then RD_WAIT. Capture ram_q into rd_byte, then DONE.
- WORD_WR:
  - Four cycles, k=0..3, with ram_addr=(base+k) mod NUMBER, ram_d=wr_word[8k+7:8k], ram_we=1.
  - Little-endian ordering.
- WORD_RD:
  - Four address cycles, k=0..3. Byte k is captured from ram_q into rd_word[8k+7:8k] the cycle after its address.
  - One extra capture cycle after the last address, then DONE.
- DONE: pulse the granted done_* for one cycle, return to IDLE.
- Address arithmetic wraps at NUMBER, e.g. base NUMBER-2 gives NUMBER-2, NUMBER-1, 0, 1.
- Outside write cycles, ram_we=0. ram_addr and ram_d hold their last value.
- busy = (|pend) | (state != IDLE).

## Timing
- All outputs are registered. Reset values: done_*=0, ram_we=0, ram_addr=0, ram_d=0, rd_byte=0, rd_word=0, busy=0, overrun=0.
- Reset also sets state=IDLE, pend=0, last_grant=3, so requester 0 wins first.
- Reset mid-operation aborts the access: no done is issued and pending requests are lost.
- Latency with the block idle, for a start sampled at edge T:
  - Byte write: ram_we high in cycle T+2, done_wr_byte in cycle T+3.
  - Byte read: address in T+2, done_rd_byte with rd_byte in T+4.
  - Word write: ram_we high T+2..T+5, done_wr_ram in T+6.
  - Word read: addresses T+2..T+5, done_rd_ram with rd_word in T+7.
- A start coinciding with its own done is accepted, because pend was already cleared at grant.
- Simultaneous starts from several requesters are all latched and served in round-robin order, back-to-back. IDLE takes one cycle between grants.
- rd_byte and rd_word hold their value until the next completed read of the same kind.

## Test plan
- RX write 0xA5 to addr 0x10, then TX read addr 0x10 -> ram_we in T+2, done_wr_byte in T+3; rd_byte=0xA5 with done_rd_byte 4 cycles after its start.
- Word write 0x11223344 at addr 0xFE (NUMBER=256) -> bytes 0x44@0xFE, 0x33@0xFF, 0x22@0x00, 0x11@0x01. Word read at 0xFE -> rd_word=0x11223344 in T+7.
- All four starts in the same cycle after reset -> grant order 0,1,2,3. Each done fires exactly once, with no overlapping RAM cycles.
- Requester 1 restarts immediately on every done while requester 0 keeps requesting -> grants alternate 0,1,0,1, with no starvation.
- Second start_wr_byte while the first is pending -> overrun=1 and only one done_wr_byte. overrun stays 1 until reset.
- Reset asserted during the third byte of a word write -> outputs return to their reset values, no done_wr_ram, busy=0 after release.
